// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider:
// FSM state encoding, default operand width and counter sizing.
package div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for seq_divider.
// Handshake: start is only looked at while the divider is idle; operands are
// captured on that same edge. done is a one-cycle pulse, and quotient,
// remainder and div_by_zero stay stable from that pulse until the next one.
interface seq_divider_if #(
    parameter int WIDTH = div_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left by one,
// pulling in the dividend MSB, trial-subtract the divisor, and keep the
// difference only when it did not go negative.
module div_step #(
    parameter int WIDTH = div_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] p_shift;
    logic [WIDTH:0] trial;

    // Shift, trial subtract and restore mux.
    always_comb begin
        p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
        trial   = p_shift - {1'b0, d};
        if (!trial[WIDTH]) begin
            p_next = trial;
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            p_next = p_shift;
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Build option: define DIV_ZERO_SHORTCUT_EN to finish a divide-by-zero in the
// accept cycle instead of iterating through all WIDTH steps.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus,
    output state_t        dbg_state
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] q_step;
    logic             accept;
    logic             last_step;
    logic             zero_shortcut;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_reg),
        .q      (q_reg),
        .d      (d_reg),
        .p_next (p_step),
        .q_next (q_step)
    );

    // Decode of handshake events and next state.
    always_comb begin
        accept     = (state == IDLE) && bus.start;
        last_step  = (state == RUN) && (cnt == CW'(1));
`ifdef DIV_ZERO_SHORTCUT_EN
        zero_shortcut = accept && (bus.divisor == '0);
`else
        zero_shortcut = 1'b0;
`endif
        state_next = state;
        case (state)
            IDLE: begin
                if (zero_shortcut) state_next = DONE;
                else if (accept)   state_next = RUN;
            end
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Working registers: load on accept, iterate while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg <= '0;
            q_reg <= '0;
            d_reg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            p_reg <= '0;
            q_reg <= bus.dividend;
            d_reg <= bus.divisor;
            cnt   <= CW'(WIDTH);
        end else if (state == RUN) begin
            p_reg <= p_step;
            q_reg <= q_step;
            cnt   <= cnt - CW'(1);
        end
    end

    // Result registers change only at completion and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else if (last_step) begin
            quotient_reg  <= q_step;
            remainder_reg <= p_step[WIDTH-1:0];
            dbz_reg       <= (d_reg == '0);
        end else if (zero_shortcut) begin
            quotient_reg  <= '1;
            remainder_reg <= bus.dividend;
            dbz_reg       <= 1'b1;
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
    assign dbg_state       = state;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, randomized operands
// against an arithmetic reference, and hand-written handshake corner cases.
module tb_seq_divider;
    import div_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edbz;
    } vec_t;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;

    seq_divider_if #(.WIDTH(W)) dut_if ();

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (dut_if.slave),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int fails  = 0;

    logic [2*W:0] exp_q[$];
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;
    logic         prev_dbz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Launch one division from an idle cycle (#1 after an edge) and check it.
    // With retrig set, start is re-raised with 10/2 during the done cycle.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit retrig);
        logic [2*W:0] e;
        int           n;
        int           exp_lat;
        logic         busy_ok;
        logic         held_ok;
        exp_q.push_back({(b == '0), ((b == '0) ? {W{1'b1}} : W'(a / b)),
                         ((b == '0) ? a : W'(a % b))});
        exp_lat = W;
`ifdef DIV_ZERO_SHORTCUT_EN
        if (b == '0) exp_lat = 0;
`endif
        dut_if.start    = 1'b1;
        dut_if.dividend = a;
        dut_if.divisor  = b;
        @(posedge clk); #1;
        dut_if.start = 1'b0;
        n = 0; busy_ok = 1'b1; held_ok = 1'b1;
        while (!dut_if.done && n < 4 * W + 4) begin
            if (!dut_if.busy) busy_ok = 1'b0;
            if (dut_if.quotient !== prev_q || dut_if.remainder !== prev_r ||
                dut_if.div_by_zero !== prev_dbz) held_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, exp_lat);
        chk("busy_while_run", busy_ok, 1);
        chk("outputs_held_in_run", held_ok, 1);
        chk("done_seen", dut_if.done, 1);
        chk("busy_at_done", dut_if.busy, 0);
        e = exp_q.pop_front();
        chk("quotient", dut_if.quotient, e[2*W-1:W]);
        chk("remainder", dut_if.remainder, e[W-1:0]);
        chk("div_by_zero", dut_if.div_by_zero, e[2*W]);
        prev_q = e[2*W-1:W]; prev_r = e[W-1:0]; prev_dbz = e[2*W];
        if (retrig) begin
            dut_if.start    = 1'b1;
            dut_if.dividend = 4'd10;
            dut_if.divisor  = 4'd2;
        end
        @(posedge clk); #1;
        dut_if.start = 1'b0;
        chk("done_one_cycle", dut_if.done, 0);
        chk("idle_after_done", dut_if.busy, 0);
        chk("hold_after_done_q", dut_if.quotient, prev_q);
    endtask

    vec_t vecs[5];
    int   n;
    int   done_cnt;

    initial begin
        vecs[0] = '{a: 4'd13, b: 4'd3, eq: 4'd4,  er: 4'd1,  edbz: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd1, eq: 4'd15, er: 4'd0,  edbz: 1'b0};
        vecs[2] = '{a: 4'd7,  b: 4'd9, eq: 4'd0,  er: 4'd7,  edbz: 1'b0};
        vecs[3] = '{a: 4'd0,  b: 4'd5, eq: 4'd0,  er: 4'd0,  edbz: 1'b0};
        vecs[4] = '{a: 4'd11, b: 4'd0, eq: 4'd15, er: 4'd11, edbz: 1'b1};

        dut_if.start = 1'b0; dut_if.dividend = '0; dut_if.divisor = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", dut_if.busy, 0);
        chk("rst_done", dut_if.done, 0);
        chk("rst_quotient", dut_if.quotient, 0);
        chk("rst_remainder", dut_if.remainder, 0);
        chk("rst_dbz", dut_if.div_by_zero, 0);
        chk("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        prev_q = '0; prev_r = '0; prev_dbz = 1'b0;
        @(posedge clk); #1;

        // Directed table: the model and the table constants must agree too.
        for (int i = 0; i < 5; i++) begin
            run_div(vecs[i].a, vecs[i].b, 1'b0);
            chk("table_q", dut_if.quotient, vecs[i].eq);
            chk("table_r", dut_if.remainder, vecs[i].er);
            chk("table_dbz", dut_if.div_by_zero, vecs[i].edbz);
        end

        // start while busy is ignored
        dut_if.start = 1'b1; dut_if.dividend = 4'd13; dut_if.divisor = 4'd3;
        @(posedge clk); #1;            // E0
        dut_if.start = 1'b0;
        @(posedge clk); #1;            // E1
        dut_if.start = 1'b1; dut_if.dividend = 4'd6; dut_if.divisor = 4'd2;
        @(posedge clk); #1;            // E2
        dut_if.start = 1'b0;
        n = 2;
        while (!dut_if.done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_start_latency", n, W);
        chk("busy_start_q", dut_if.quotient, 4);
        chk("busy_start_r", dut_if.remainder, 1);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (dut_if.done) done_cnt++;
        end
        chk("no_second_done", done_cnt, 0);
        prev_q = 4'd4; prev_r = 4'd1; prev_dbz = 1'b0;

        // reset in the middle of a run
        dut_if.start = 1'b1; dut_if.dividend = 4'd13; dut_if.divisor = 4'd3;
        @(posedge clk); #1;
        dut_if.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;            // E2
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", dut_if.busy, 0);
        chk("midrst_done", dut_if.done, 0);
        chk("midrst_q", dut_if.quotient, 0);
        chk("midrst_r", dut_if.remainder, 0);
        chk("midrst_state", dbg_state, IDLE);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (dut_if.done) done_cnt++;
        end
        chk("midrst_no_done", done_cnt, 0);
        rst_n = 1'b1;
        prev_q = '0; prev_r = '0; prev_dbz = 1'b0;
        @(posedge clk); #1;
        run_div(4'd9, 4'd4, 1'b0);

        // back-to-back: start in the done cycle is dropped, then re-issued
        run_div(4'd13, 4'd3, 1'b1);
        chk("b2b_ignored_r", dut_if.remainder, 1);
        run_div(4'd10, 4'd2, 1'b0);
        chk("b2b_q", dut_if.quotient, 5);
        chk("b2b_r", dut_if.remainder, 0);

        // randomized operands against the arithmetic reference
        for (int i = 0; i < 30; i++) begin
            run_div(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
